stream_arbiter: RTL
===================

STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data width of each stream in bits.
REQ-002 The block SHALL have parameter COUNT, default 2, meaning the number of input streams (2..16).
REQ-003 Derived width SEL_W SHALL be max(1, clog2(COUNT)).
REQ-004 clk  input  1  the single clock; every register is on the rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 s_valid  input  COUNT  per-stream beat valid.
REQ-007 s_ready  output  COUNT  per-stream beat accept.
REQ-008 s_data  input  COUNT*WIDTH  per-stream data; stream i occupies bits [i*WIDTH +: WIDTH].
REQ-009 s_last  input  COUNT  per-stream final beat of a packet.
REQ-010 m_valid  output  1  output beat valid.
REQ-011 m_ready  input  1  output beat accept.
REQ-012 m_data  output  WIDTH  output data.
REQ-013 m_last  output  1  final beat of the output packet.
REQ-014 m_select  output  SEL_W  index of the source stream of the current output beat.

Function
REQ-015 A transfer SHALL occur on any port whose valid and ready are both high at a rising edge.
REQ-016 The output stage SHALL be one register (m_valid, m_data, m_last, m_select); it loads when load = ~m_valid | m_ready.
REQ-017 Input-to-output latency SHALL be exactly 1 cycle; sustained throughput SHALL be 1 beat/cycle while m_ready stays high.
REQ-018 The block SHALL hold state IDLE or LOCKED, a grant index G (SEL_W bits) and a priority pointer P (SEL_W bits).
REQ-019 In IDLE the candidate SHALL be the first i with s_valid[i] high, searching P+1, P+2, … modulo COUNT (round-robin, P lowest priority).
REQ-020 In LOCKED the candidate SHALL be G regardless of other s_valid.
REQ-021 s_ready[i] SHALL be high only when i is the candidate, load is high, and (in IDLE) s_valid[i] is high; at most one s_ready bit SHALL be high in any cycle.
REQ-022 s_ready SHALL be combinational from state, s_valid and m_ready; s_ready SHALL NOT depend on s_data or s_last.
REQ-023 On an IDLE transfer from i with s_last[i]=0: next state LOCKED, G<=i.
REQ-024 On an IDLE transfer from i with s_last[i]=1: remain IDLE, P<=i.
REQ-025 On a LOCKED transfer with s_last[G]=1: next state IDLE, P<=G; with s_last[G]=0: remain LOCKED.
REQ-026 On any transfer the output register SHALL take m_valid=1, m_data=s_data[i], m_last=s_last[i], m_select=i.
REQ-027 When load is high and no transfer occurs, m_valid SHALL go to 0; when load is low, all output registers SHALL hold.
REQ-028 While m_valid=1 and m_ready=0, m_data, m_last and m_select SHALL remain stable.
REQ-029 Beats of one packet SHALL never interleave with beats of another packet on the output.
REQ-030 In LOCKED with s_valid[G]=0, the block SHALL wait (bubble) and SHALL NOT grant another stream.
REQ-031 P SHALL change only at end of packet, so a stream that has just finished SHALL have lowest priority for the next grant.
REQ-032 With COUNT=1 the block SHALL degenerate to a 1-stage register slice with m_select=0.

Reset
REQ-033 While reset_n=0: state=IDLE, G=0, P=COUNT-1, m_valid=0, m_last=0, m_select=0, m_data=0, s_ready=0.
REQ-034 Reset asserted mid-packet SHALL discard the lock and any registered output beat; no partial-packet completion is generated.
REQ-035 The first grant after reset release SHALL go to the lowest-index valid stream.

Verification
REQ-036 COUNT=2, both streams send 1-beat packets continuously, m_ready=1 -> m_select alternates 0,1,0,1 with no bubbles, first beat 1 cycle after the first transfer.
REQ-037 Stream 0 sends a 4-beat packet (A0..A3) while stream 1 holds valid -> output A0..A3 contiguous with m_last on A3, then stream 1's beat; s_ready[1]=0 throughout A0..A3.
REQ-038 m_ready held low 3 cycles while m_valid=1, data 0xDEADBEEF -> m_data stays 0xDEADBEEF, s_ready all 0, no beat lost or duplicated.
REQ-039 LOCKED on stream 1, s_valid[1] drops 2 cycles while stream 0 is valid -> m_valid=0 for those cycles, stream 0 not granted until stream 1's last beat.
REQ-040 reset_n pulsed low mid-packet -> outputs clear asynchronously; after release, stream 0 is granted first (P=COUNT-1).
REQ-041 Random valid/ready/last, COUNT=4, 10k cycles -> scoreboard per-stream order preserved, no packet interleave, at most one s_ready high per cycle.

Source files
------------

// File: rtl/stream_arbiter_if.sv
// Stream arbiter bus: COUNT input streams with valid/ready/last, one registered output stream.
// master is the arbiter side; slave is the environment driving sources and sinking the output.
interface stream_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int COUNT = 2
);
  localparam int SEL_W = (COUNT > 1) ? $clog2(COUNT) : 1;

  logic [COUNT-1:0]       s_valid;
  logic [COUNT-1:0]       s_ready;
  logic [COUNT*WIDTH-1:0] s_data;
  logic [COUNT-1:0]       s_last;
  logic                   m_valid;
  logic                   m_ready;
  logic [WIDTH-1:0]       m_data;
  logic                   m_last;
  logic [SEL_W-1:0]       m_select;

  modport master (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, m_select
  );

  modport slave (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_select
  );
endinterface

// File: rtl/stream_arbiter.sv
// Packet-atomic round-robin arbiter into a single output register: 1-cycle latency, 1 beat/cycle.
// Backpressure: inputs are granted only when the output register can load (~m_valid | m_ready).
module stream_arbiter #(
  parameter int WIDTH = 32,
  parameter int COUNT = 2
) (
  input logic              clk,
  input logic              reset_n,
  stream_arbiter_if.master bus
);
  localparam int SEL_W = (COUNT > 1) ? $clog2(COUNT) : 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEL_W-1:0] r_grant;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] w_grant_nxt;
  logic [SEL_W-1:0] w_ptr_nxt;
  logic [SEL_W-1:0] w_cand;
  logic [SEL_W-1:0] w_idx;
  logic             w_found;
  logic             w_load;
  logic             w_xfer;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= SEL_W'(COUNT - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Round-robin search starts just past the last finished stream, so it ranks lowest.
  always_comb begin
    w_cand  = r_grant;
    w_found = 1'b0;
    w_idx   = '0;
    if (r_state == LOCKED) begin
      w_found = bus.s_valid[r_grant];
    end else begin
      for (int k = 1; k <= COUNT; k++) begin
        w_idx = SEL_W'((int'(r_ptr) + k) % COUNT);
        if (!w_found && bus.s_valid[w_idx]) begin
          w_found = 1'b1;
          w_cand  = w_idx;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    if (w_xfer) begin
      if (r_state == IDLE) begin
        if (bus.s_last[w_cand]) begin
          w_ptr_nxt = w_cand;
        end else begin
          w_state_nxt = LOCKED;
          w_grant_nxt = w_cand;
        end
      end else if (bus.s_last[r_grant]) begin
        w_state_nxt = IDLE;
        w_ptr_nxt   = r_grant;
      end
    end
  end

  // A locked stream keeps its ready while load is high even if its valid drops.
  always_comb begin
    w_load      = ~bus.m_valid | bus.m_ready;
    w_xfer      = w_load & w_found;
    bus.s_ready = '0;
    if (reset_n && w_load && (r_state == LOCKED || w_found)) begin
      bus.s_ready[w_cand] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.m_valid  <= 1'b0;
      bus.m_data   <= '0;
      bus.m_last   <= 1'b0;
      bus.m_select <= '0;
    end else if (w_load) begin
      bus.m_valid <= w_xfer;
      if (w_xfer) begin
        bus.m_data   <= bus.s_data[int'(w_cand)*WIDTH +: WIDTH];
        bus.m_last   <= bus.s_last[w_cand];
        bus.m_select <= w_cand;
      end
    end
  end
endmodule
